// File: rtl/spectrogram_frame_receiver.sv
// Receive-side deserializer for the spectrogram serial readout link.
// Rebuilds the timestamp header and data words, counts words per frame and flags framing errors.
module spectrogram_frame_receiver #(
  parameter int TS_W      = 31,
  parameter int WORD_W    = 8,
  parameter int MAX_WORDS = 400,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_frame,
  input  logic              s_bit_valid,
  input  logic              s_sel,
  input  logic              s_data,
  output logic [TS_W-1:0]   ts_out,
  output logic              ts_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic [CNT_W-1:0]  word_idx,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_words,
  output logic              err_hdr,
  output logic              err_partial,
  output logic              err_ovf,
  output logic [1:0]        dbg_state
);

  localparam int BIT_W = $clog2((TS_W > WORD_W) ? TS_W : WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_END  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              frame_prev_q;
  logic [TS_W-1:0]   hdr_sr_q, hdr_sr_d;
  logic [WORD_W-1:0] word_sr_q, word_sr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [TS_W-1:0]   ts_out_q, ts_out_d;
  logic              ts_valid_q, ts_valid_d;
  logic [WORD_W-1:0] word_out_q, word_out_d;
  logic              word_valid_q, word_valid_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_words_q, frame_words_d;
  logic              err_hdr_q, err_hdr_d;
  logic              err_partial_q, err_partial_d;
  logic              err_ovf_q, err_ovf_d;

  // Link semantics: a bit is consumed only when s_bit_valid is high while s_frame is high;
  // there is no back-pressure, every qualified strobe must be absorbed in its cycle.
  logic strobe, frame_rise, hdr_bit;
  assign strobe     = s_bit_valid && s_frame;
  assign frame_rise = s_frame && !frame_prev_q;

  always_comb begin
    state_d       = state_q;
    hdr_sr_d      = hdr_sr_q;
    word_sr_d     = word_sr_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    ts_out_d      = ts_out_q;
    ts_valid_d    = 1'b0;
    word_out_d    = word_out_q;
    word_valid_d  = 1'b0;
    word_idx_d    = word_idx_q;
    frame_done_d  = 1'b0;
    frame_words_d = frame_words_q;
    err_hdr_d     = err_hdr_q;
    err_partial_d = err_partial_q;
    err_ovf_d     = err_ovf_q;
    hdr_bit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_rise) begin
          state_d       = ST_HDR;
          hdr_sr_d      = '0;
          word_sr_d     = '0;
          bit_cnt_d     = '0;
          word_cnt_d    = '0;
          err_hdr_d     = 1'b0;
          err_partial_d = 1'b0;
          err_ovf_d     = 1'b0;
          hdr_bit       = 1'b1;
        end
      end
      ST_HDR: begin
        if (!s_frame) begin
          state_d       = ST_END;
          err_partial_d = 1'b1;
          bit_cnt_d     = '0;
        end else begin
          hdr_bit = 1'b1;
        end
      end
      ST_DATA: begin
        if (!s_frame) begin
          state_d = ST_END;
          if (bit_cnt_q != '0) err_partial_d = 1'b1;
          bit_cnt_d = '0;
        end else if (strobe) begin
          if (!s_sel) begin
            err_hdr_d = 1'b1;
          end else begin
            word_sr_d = {word_sr_q[WORD_W-2:0], s_data};
            if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
              bit_cnt_d = '0;
              // Counter saturates at MAX_WORDS; surplus words are dropped.
              if (word_cnt_q == CNT_W'(MAX_WORDS)) begin
                err_ovf_d = 1'b1;
              end else begin
                word_out_d   = word_sr_d;
                word_idx_d   = word_cnt_q;
                word_valid_d = 1'b1;
                word_cnt_d   = word_cnt_q + CNT_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end
      ST_END: begin
        frame_done_d  = 1'b1;
        frame_words_d = word_cnt_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Header bit handling is shared by HDR and the frame-start cycle in IDLE.
    if (hdr_bit && strobe) begin
      if (s_sel) begin
        err_hdr_d = 1'b1;
      end else begin
        hdr_sr_d = {hdr_sr_d[TS_W-2:0], s_data};
        if (bit_cnt_d == BIT_W'(TS_W - 1)) begin
          ts_out_d   = hdr_sr_d;
          ts_valid_d = 1'b1;
          bit_cnt_d  = '0;
          state_d    = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_d + BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_prev_q  <= 1'b0;
      hdr_sr_q      <= '0;
      word_sr_q     <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      ts_out_q      <= '0;
      ts_valid_q    <= 1'b0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      word_idx_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_words_q <= '0;
      err_hdr_q     <= 1'b0;
      err_partial_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_prev_q  <= s_frame;
      hdr_sr_q      <= hdr_sr_d;
      word_sr_q     <= word_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      ts_out_q      <= ts_out_d;
      ts_valid_q    <= ts_valid_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      word_idx_q    <= word_idx_d;
      frame_done_q  <= frame_done_d;
      frame_words_q <= frame_words_d;
      err_hdr_q     <= err_hdr_d;
      err_partial_q <= err_partial_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign ts_out      = ts_out_q;
  assign ts_valid    = ts_valid_q;
  assign word_out    = word_out_q;
  assign word_valid  = word_valid_q;
  assign word_idx    = word_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_words = frame_words_q;
  assign err_hdr     = err_hdr_q;
  assign err_partial = err_partial_q;
  assign err_ovf     = err_ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// Bench for spectrogram_frame_receiver: random serial frames checked against a
// frame-level model that derives timestamp, words and error flags from the bit list.
module tb_spectrogram_frame_receiver;

  localparam int TS_W      = 31;
  localparam int WORD_W    = 8;
  localparam int MAX_WORDS = 400;
  localparam int CNT_W     = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, s_frame, s_bit_valid, s_sel, s_data;
  logic [TS_W-1:0]   ts_out;
  logic              ts_valid;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic [CNT_W-1:0]  word_idx;
  logic              frame_done;
  logic [CNT_W-1:0]  frame_words;
  logic              err_hdr, err_partial, err_ovf;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  spectrogram_frame_receiver #(
    .TS_W(TS_W), .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .s_frame(s_frame), .s_bit_valid(s_bit_valid),
    .s_sel(s_sel), .s_data(s_data), .ts_out(ts_out), .ts_valid(ts_valid),
    .word_out(word_out), .word_valid(word_valid), .word_idx(word_idx),
    .frame_done(frame_done), .frame_words(frame_words), .err_hdr(err_hdr),
    .err_partial(err_partial), .err_ovf(err_ovf), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [TS_W-1:0]         exp_ts_q[$];
  logic [CNT_W+WORD_W-1:0] exp_q[$];
  bit st_sel[$];
  bit st_dat[$];
  int exp_fw;
  bit exp_eh, exp_ep, exp_eo;
  bit done_pending = 1'b0;
  bit got_done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cleared(input string pfx);
    check_val({pfx, "_ts_out"}, 64'(ts_out), 0);
    check_val({pfx, "_ts_valid"}, 64'(ts_valid), 0);
    check_val({pfx, "_word_out"}, 64'(word_out), 0);
    check_val({pfx, "_word_valid"}, 64'(word_valid), 0);
    check_val({pfx, "_word_idx"}, 64'(word_idx), 0);
    check_val({pfx, "_frame_done"}, 64'(frame_done), 0);
    check_val({pfx, "_frame_words"}, 64'(frame_words), 0);
    check_val({pfx, "_err_hdr"}, 64'(err_hdr), 0);
    check_val({pfx, "_err_partial"}, 64'(err_partial), 0);
    check_val({pfx, "_err_ovf"}, 64'(err_ovf), 0);
    check_val({pfx, "_state"}, 64'(dbg_state), 0);
  endtask

  // ---------------- reference model ----------------
  // Header = the first TS_W timestamp-select bits; every data-select bit before that is an
  // error. After the header, data-select bits group into words of WORD_W, the first
  // MAX_WORDS of which are delivered; stray timestamp-select bits are errors.
  task automatic model_frame();
    int hb = 0;
    int db = 0;
    int wc = 0;
    logic [TS_W-1:0]   ts = '0;
    logic [WORD_W-1:0] w = '0;
    exp_eh = 1'b0;
    exp_eo = 1'b0;
    foreach (st_sel[i]) begin
      if (hb < TS_W) begin
        if (st_sel[i]) exp_eh = 1'b1;
        else begin
          ts[TS_W-1-hb] = st_dat[i];
          hb++;
          if (hb == TS_W) exp_ts_q.push_back(ts);
        end
      end else if (!st_sel[i]) begin
        exp_eh = 1'b1;
      end else begin
        w[WORD_W-1-db] = st_dat[i];
        db++;
        if (db == WORD_W) begin
          db = 0;
          if (wc < MAX_WORDS) begin
            exp_q.push_back({CNT_W'(wc), w});
            wc++;
          end else exp_eo = 1'b1;
        end
      end
    end
    exp_ep = (hb < TS_W) || (db != 0);
    exp_fw = wc;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ts_valid) begin
      if (exp_ts_q.size() == 0) check_val("ts_unexpected", 1, 0);
      else check_val("ts_out", 64'(ts_out), 64'(exp_ts_q.pop_front()));
    end
    if (word_valid) begin
      if (exp_q.size() == 0) check_val("word_unexpected", 64'(word_idx), 64'hFFFF);
      else check_val("word_idx_data", 64'({word_idx, word_out}), 64'(exp_q.pop_front()));
    end
    if (frame_done) begin
      if (!done_pending) check_val("spurious_frame_done", 1, 0);
      else begin
        check_val("frame_words", 64'(frame_words), 64'(exp_fw));
        check_val("err_hdr", 64'(err_hdr), 64'(exp_eh));
        check_val("err_partial", 64'(err_partial), 64'(exp_ep));
        check_val("err_ovf", 64'(err_ovf), 64'(exp_eo));
        got_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_hdr(input logic [TS_W-1:0] ts);
    for (int i = TS_W - 1; i >= 0; i--) begin
      st_sel.push_back(1'b0);
      st_dat.push_back(ts[i]);
    end
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      st_sel.push_back(1'b1);
      st_dat.push_back(w[i]);
    end
  endtask

  task automatic send_bits(input int gap_max);
    s_frame = 1'b1;
    foreach (st_sel[i]) begin
      s_bit_valid = 1'b1;
      s_sel       = st_sel[i];
      s_data      = st_dat[i];
      @(posedge clk); #1;
      s_bit_valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input int gap_max);
    model_frame();
    done_pending = 1'b1;
    got_done = 1'b0;
    send_bits(gap_max);
    s_frame = 1'b0;
    s_bit_valid = 1'b0;
    for (int i = 0; i < 8 && !got_done; i++) @(posedge clk);
    #1;
    if (!got_done) check_val("frame_done_timeout", 0, 1);
    check_val("ts_left", 64'(exp_ts_q.size()), 0);
    check_val("words_left", 64'(exp_q.size()), 0);
    done_pending = 1'b0;
    st_sel.delete();
    st_dat.delete();
    exp_ts_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; s_frame = 1'b0; s_bit_valid = 1'b0; s_sel = 1'b0; s_data = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // nominal short frame
    push_hdr(31'h1234_5678);
    push_word(8'hA5); push_word(8'h3C); push_word(8'hFF);
    run_frame(0);

    // full two-bank frame with idle gaps
    push_hdr(TS_W'($urandom));
    for (int i = 0; i < MAX_WORDS; i++) push_word(WORD_W'(i));
    run_frame(2);

    // overflow by one word
    push_hdr(TS_W'($urandom));
    for (int i = 0; i <= MAX_WORDS; i++) push_word(WORD_W'(i));
    run_frame(0);

    // early data bit inside the header
    begin
      logic [TS_W-1:0] ts = TS_W'($urandom);
      for (int i = TS_W - 1; i >= 0; i--) begin
        if (i == TS_W - 11) begin st_sel.push_back(1'b1); st_dat.push_back(1'b1); end
        st_sel.push_back(1'b0); st_dat.push_back(ts[i]);
      end
      push_word(WORD_W'($urandom)); push_word(WORD_W'($urandom));
      run_frame(1);
    end

    // truncation after 5 bits of the third word, then a clean frame
    push_hdr(TS_W'($urandom));
    push_word(8'h11); push_word(8'h22);
    for (int i = 0; i < 5; i++) begin st_sel.push_back(1'b1); st_dat.push_back(1'($urandom)); end
    run_frame(0);
    push_hdr(TS_W'($urandom));
    push_word(WORD_W'($urandom));
    run_frame(0);

    // random frames: stray header bits in data, trailing partial words, empty frames
    for (int f = 0; f < 6; f++) begin
      int nw = $urandom_range(0, 5);
      push_hdr(TS_W'($urandom));
      for (int i = 0; i < nw; i++) begin
        push_word(WORD_W'($urandom));
        if ($urandom_range(0, 5) == 0) begin st_sel.push_back(1'b0); st_dat.push_back(1'($urandom)); end
      end
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, WORD_W - 1)) begin st_sel.push_back(1'b1); st_dat.push_back(1'($urandom)); end
      run_frame(2);
    end

    // reset in DATA after two words; the aborted frame must not report frame_done
    push_hdr(TS_W'($urandom));
    push_word(WORD_W'($urandom)); push_word(WORD_W'($urandom));
    for (int i = 0; i < 3; i++) begin st_sel.push_back(1'b1); st_dat.push_back(1'($urandom)); end
    model_frame();
    done_pending = 1'b0;
    send_bits(0);
    reset = 1'b1; s_frame = 1'b0; s_bit_valid = 1'b0;
    @(negedge clk);
    check_cleared("midreset");
    check_val("midreset_words_left", 64'(exp_q.size()), 0);
    st_sel.delete(); st_dat.delete(); exp_ts_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    push_hdr(31'h1234_5678);
    push_word(8'hA5); push_word(8'h3C); push_word(8'hFF);
    run_frame(0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
